// File: rtl/alu_pkg.sv
// Shared arithmetic-unit definitions: sequencer state encoding and default operand width.
package alu_pkg;

    localparam int SUB_WIDTH_DEFAULT = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sub1.sv
// 1-bit full subtractor: out = a - b - bin, borrow_out set when the bit underflows.
module sub1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic out,
    output logic borrow_out
);

    assign out        = a ^ b ^ bin;
    assign borrow_out = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/sub_serial_ctrl.sv
// Bit-serial WIDTH-bit subtractor (a - b - borrow_in), LSB first, one sub1 cell reused per clock.
// Optional zero/ovf result flags are built when SUB_SERIAL_FLAGS_EN is defined.
module sub_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
`ifdef SUB_SERIAL_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output state_t           state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; the producer holds valid and data stable until that edge.

    state_t           state_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic             borrow_q;
    logic [CNT_W-1:0] count;
    logic             bit_out;
    logic             bit_borrow;
    logic             last_bit;

    sub1 u_sub1 (
        .a          (a_sh[0]),
        .b          (b_sh[0]),
        .bin        (borrow_q),
        .out        (bit_out),
        .borrow_out (bit_borrow)
    );

    assign last_bit = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            diff_sh  <= '0;
            borrow_q <= 1'b0;
            count    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        borrow_q <= borrow_in;
                        count    <= '0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    diff_sh  <= {bit_out, diff_sh[WIDTH-1:1]};
                    borrow_q <= bit_borrow;
                    // Counter holds at its terminal value rather than wrapping.
                    if (last_bit) begin
                        state_q <= ST_DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SUB_SERIAL_FLAGS_EN
    logic a_msb;
    logic b_msb;
    logic zero_q;
    logic ovf_q;

    // Flags are resolved on the final RUN edge, when the MSB difference bit is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == ST_IDLE && in_valid) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state_q == ST_RUN && last_bit) begin
            zero_q <= ({bit_out, diff_sh[WIDTH-1:1]} == '0);
            ovf_q  <= (a_msb != b_msb) && (bit_out != a_msb);
        end
    end

    assign zero = zero_q;
    assign ovf  = ovf_q;
`endif

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q == ST_RUN);
    assign diff       = diff_sh;
    assign borrow_out = borrow_q;
    assign state      = state_q;

endmodule

// File: tb/tb_sub_serial_ctrl.sv
// Scoreboard bench for sub_serial_ctrl at WIDTH=4 using hand-computed directed vectors.
module tb_sub_serial_ctrl;
    import alu_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
    state_t       state;
`ifdef SUB_SERIAL_FLAGS_EN
    logic         zero;
    logic         ovf;
`endif

    sub_serial_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
`ifdef SUB_SERIAL_FLAGS_EN
        .zero       (zero),
        .ovf        (ovf),
`endif
        .state      (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // expected entry: {ovf, zero, borrow_out, diff}
    logic [6:0] exp_q[$];
    int         acc_q[$];
    int         acc_cyc = 0;
    bit         prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // driver: present operands after a posedge, hold until accepted
    task automatic issue(input logic [3:0] av, input logic [3:0] bv, input logic bi,
                         input logic [3:0] ed, input logic eb, input logic ez,
                         input logic eo, input bit hold);
        int waited;
        exp_q.push_back({eo, ez, eb, ed});
        a = av;
        b = bv;
        borrow_in = bi;
        in_valid = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 100);
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_diff"}, diff, 0);
        check({tag, "_borrow"}, borrow_out, 0);
        check({tag, "_state"}, state, ST_IDLE);
`ifdef SUB_SERIAL_FLAGS_EN
        check({tag, "_zero"}, zero, 0);
        check({tag, "_ovf"}, ovf, 0);
`endif
    endtask

    // monitor: samples at negedge, values match those seen by the next posedge
    initial begin
        logic [6:0] got;
        logic [6:0] expv;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    acc_cyc = cyc;
                    acc_q.push_back(cyc);
                end
                if (out_valid && !prev_valid) check("latency", cyc - acc_cyc, W + 1);
                prev_valid = out_valid;
                if (out_valid) begin
                    check("in_ready_in_done", in_ready, 0);
                    got = {2'b00, borrow_out, diff};
`ifdef SUB_SERIAL_FLAGS_EN
                    got[6:5] = {ovf, zero};
`endif
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        expv = exp_q[0];
`ifndef SUB_SERIAL_FLAGS_EN
                        expv[6:5] = 2'b00;
`endif
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            check("result", got, expv);
                        end else begin
                            check("held_result", got, expv);
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // 1) basic, 2) borrow cases, plus signed-overflow vector
        @(posedge clk); #1;
        issue(4'd7, 4'd3, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        issue(4'd3, 4'd7, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        issue(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        issue(4'd10, 4'd4, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        issue(4'd15, 4'd0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // 3) back-pressure: result held in DONE for 10 cycles
        out_ready = 1'b0;
        issue(4'd12, 4'd5, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        begin
            int waited = 0;
            while (!out_valid && waited < 50) begin
                @(posedge clk); #1;
                waited++;
            end
            check("done_reached", out_valid, 1);
        end
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // 4) reset on the second RUN cycle, then a clean op
        issue(4'd6, 4'd1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        check_reset_outputs("abort");
        rst = 1'b0;
        @(posedge clk); #1;
        issue(4'd9, 4'd2, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // 5) in_valid held across three ops; 6) flag vectors
        acc_q.delete();
        issue(4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(4'd1,  4'd2,  1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(4'd8,  4'd1,  1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        check("accept_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("accept_gap_1", acc_q[1] - acc_q[0], W + 2);
            check("accept_gap_2", acc_q[2] - acc_q[1], W + 2);
        end
        issue(4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
